// File: rtl/proc_scheduler_pkg.sv
// proc_sched_pkg: shared scheduler state encoding, limits and id-width helper
package proc_sched_pkg;
    localparam int NPROC_MAX = 16;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2, GAP = 2'd3} schedState_t;
    function automatic int idWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/proc_scheduler_if.sv
// proc_scheduler_if: per-processor request lanes plus the shared owner-gated bus
interface proc_scheduler_if #(
    parameter int NPROC  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    import proc_sched_pkg::*;
    localparam int IDW = idWidth(NPROC);
    logic [NPROC-1:0]        P_MEM_EN, P_MEM_WR, P_GPU_DRAW, P_IACK, P_IEND;
    logic [NPROC-1:0]        P_SW_REQ, P_SW_TGT_VLD, P_ENABLE;
    logic [NPROC*ADDR_W-1:0] P_MEM_ADDR;
    logic [NPROC*DATA_W-1:0] P_MEM_DATAW;
    logic [NPROC*IDW-1:0]    P_SW_TGT;
    logic [IDW-1:0]          ACTIVE_ID;
    logic                    MEM_EN, MEM_WR, GPU_DRAW, IACK, IEND, SWITCHING;
    logic [ADDR_W-1:0]       MEM_ADDR;
    logic [DATA_W-1:0]       MEM_DATAW;
    modport master (
        output P_MEM_EN, P_MEM_WR, P_MEM_ADDR, P_MEM_DATAW, P_GPU_DRAW, P_IACK, P_IEND,
               P_SW_REQ, P_SW_TGT_VLD, P_SW_TGT,
        input  P_ENABLE, ACTIVE_ID, MEM_EN, MEM_WR, MEM_ADDR, MEM_DATAW, GPU_DRAW,
               IACK, IEND, SWITCHING
    );
    modport slave (
        input  P_MEM_EN, P_MEM_WR, P_MEM_ADDR, P_MEM_DATAW, P_GPU_DRAW, P_IACK, P_IEND,
               P_SW_REQ, P_SW_TGT_VLD, P_SW_TGT,
        output P_ENABLE, ACTIVE_ID, MEM_EN, MEM_WR, MEM_ADDR, MEM_DATAW, GPU_DRAW,
               IACK, IEND, SWITCHING
    );
endinterface

// File: rtl/proc_scheduler_quantum_timer.sv
// sched_quantum_timer: counts RUN cycles and flags the last cycle of the quantum
module sched_quantum_timer #(
    parameter int QUANTUM = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [QW-1:0] LAST = QW'(QUANTUM - 1);
    logic [QW-1:0] qcount;
    assign expire = run && qcount == LAST;
    always_ff @(posedge CLK) begin
        if (RESET || clear) qcount <= '0;
        else if (run && qcount != LAST) qcount <= qcount + QW'(1);
    end
endmodule

// File: rtl/proc_scheduler.sv
// proc_scheduler: hands one shared memory/GPU/IRQ bus between NPROC soft processors
module proc_scheduler #(
    parameter int NPROC   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int QUANTUM = 0
) (
    input logic             CLK,
    input logic             RESET,
    proc_scheduler_if.slave bus
);
    import proc_sched_pkg::*;
    localparam int IDW = idWidth(NPROC);
    schedState_t    state, stateNext;
    logic [IDW-1:0] activeId, idNext, dest, destNext, tgt, rrNext, destSel;
    logic           inService, svcNext, busOn, ownerReq, tgtOk, expire, quiet, iack, iend;

    assign busOn    = state == RUN || state == DRAIN;
    assign ownerReq = bus.P_SW_REQ[activeId];
    assign tgt      = bus.P_SW_TGT[activeId*IDW +: IDW];
    assign rrNext   = (activeId == IDW'(NPROC - 1)) ? '0 : activeId + IDW'(1);
    assign tgtOk    = bus.P_SW_TGT_VLD[activeId] && int'(tgt) < NPROC && tgt != activeId;
    assign destSel  = (ownerReq && tgtOk) ? tgt : rrNext;
    assign iack     = busOn && bus.P_IACK[activeId];
    assign iend     = busOn && bus.P_IEND[activeId];
    assign svcNext  = iend ? 1'b0 : (iack || inService);
    assign quiet    = !bus.P_MEM_EN[activeId] && !inService;

    generate
        if (QUANTUM > 0) begin : g_quantum
            sched_quantum_timer #(.QUANTUM(QUANTUM)) u_timer (
                .CLK(CLK), .RESET(RESET), .clear(state != RUN), .run(state == RUN), .expire(expire)
            );
        end else begin : g_no_quantum
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= BOOT;
            activeId  <= '0;
            dest      <= '0;
            inService <= 1'b0;
        end else begin
            state     <= stateNext;
            activeId  <= idNext;
            dest      <= destNext;
            inService <= svcNext;
        end
    end

    // A voluntary request and quantum expiry share one transition; destSel prefers the request.
    always_comb begin
        stateNext = state;
        idNext    = activeId;
        destNext  = dest;
        case (state)
            BOOT:    stateNext = RUN;
            RUN:     if (ownerReq || expire) begin
                         stateNext = DRAIN;
                         destNext  = destSel;
                     end
            DRAIN:   if (quiet) stateNext = GAP;
            GAP:     begin
                         stateNext = RUN;
                         idNext    = dest;
                     end
            default: stateNext = BOOT;
        endcase
    end

    assign bus.P_ENABLE  = busOn ? NPROC'(1) << activeId : '0;
    assign bus.ACTIVE_ID = activeId;
    assign bus.MEM_EN    = busOn && bus.P_MEM_EN[activeId];
    assign bus.MEM_WR    = busOn && bus.P_MEM_WR[activeId];
    assign bus.GPU_DRAW  = busOn && bus.P_GPU_DRAW[activeId];
    assign bus.IACK      = iack;
    assign bus.IEND      = iend;
    assign bus.MEM_ADDR  = busOn ? bus.P_MEM_ADDR[activeId*ADDR_W +: ADDR_W] : '0;
    assign bus.MEM_DATAW = busOn ? bus.P_MEM_DATAW[activeId*DATA_W +: DATA_W] : '0;
    assign bus.SWITCHING = state == DRAIN || state == GAP;
endmodule
